// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, 5..MAX_DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
// All frame settings are captured at acceptance, and the outputs are registered.
module uart_tx_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter int BAUD_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic [BAUD_WIDTH-1:0]    cfg_baud_div,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    state_t                   state_q, state_d;
    logic [BAUD_WIDTH-1:0]    cnt_q, cnt_d;
    logic [BAUD_WIDTH-1:0]    div_q, div_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]               nbits_q, nbits_d;
    logic [3:0]               bit_idx_q, bit_idx_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     stop2_q, stop2_d;
    logic                     stop_idx_q, stop_idx_d;
    logic                     tx_q, tx_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [3:0]               nbits_in;
    logic [MAX_DATA_BITS-1:0] masked_in;
    logic                     par_en_in;
    logic                     par_bit_in;
    logic [BAUD_WIDTH-1:0]    div_in;
    logic                     accept;
    logic                     bit_end;
    logic                     last_stop;
    logic [BAUD_WIDTH-1:0]    reload;

    // Frame settings as they would be captured on an accept this cycle.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        nbits_in   = cfg_data_bits;
        masked_in  = '0;
        par_en_in  = 1'b0;
        par_bit_in = 1'b0;
        div_in     = cfg_baud_div;

        if (cfg_data_bits < 4'd5) begin
            nbits_in = 4'd5;
        end else if (cfg_data_bits > 4'(MAX_DATA_BITS)) begin
            nbits_in = 4'(MAX_DATA_BITS);
        end

        // Bits above the effective length never reach the line or the parity.
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            masked_in[i] = tx_data[i] && (4'(i) < nbits_in);
        end

        case (cfg_parity)
            PAR_EVEN:  begin par_en_in = 1'b1; par_bit_in = ^masked_in;  end
            PAR_ODD:   begin par_en_in = 1'b1; par_bit_in = ~^masked_in; end
            PAR_MARK:  begin par_en_in = 1'b1; par_bit_in = 1'b1;        end
            PAR_SPACE: begin par_en_in = 1'b1; par_bit_in = 1'b0;        end
            default:   begin par_en_in = 1'b0; par_bit_in = 1'b0;        end
        endcase

        if (cfg_baud_div == '0) begin
            div_in = BAUD_WIDTH'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        tx_d       = 1'b1;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        accept  = tx_valid && ready_q;
        bit_end = (cnt_q == '0);
        reload  = div_q - BAUD_WIDTH'(1);

        case (state_q)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = reload;
                    bit_idx_d = 4'd0;
                end else begin
                    cnt_d = cnt_q - BAUD_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = reload;
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - BAUD_WIDTH'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    cnt_d      = reload;
                    stop_idx_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - BAUD_WIDTH'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = reload;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - BAUD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // ready_q is only high in IDLE or the final stop cycle, so an accept always starts a fresh frame.
        if (accept) begin
            state_d    = START;
            cnt_d      = div_in - BAUD_WIDTH'(1);
            div_d      = div_in;
            shift_d    = masked_in;
            nbits_d    = nbits_in;
            bit_idx_d  = 4'd0;
            par_en_d   = par_en_in;
            par_bit_d  = par_bit_in;
            stop2_d    = cfg_stop2;
            stop_idx_d = 1'b0;
        end

        // Outputs are derived from the next state so that, once registered, they line up with it.
        last_stop = (state_d == STOP) && (cnt_d == '0) && (!stop2_d || stop_idx_d);
        ready_d   = (state_d == IDLE) || last_stop;
        done_d    = last_stop;
        busy_d    = (state_d != IDLE);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= BAUD_WIDTH'(1);
            shift_q    <= '0;
            nbits_q    <= 4'd5;
            bit_idx_q  <= 4'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: hand-computed line waveforms checked cycle by cycle.
// Frame patterns are given as bit vectors, where bit k is the k-th bit period on tx (bit 0 = start bit).
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_valid;
    logic [8:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop2;
    logic [31:0] cfg_baud_div;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    uart_tx_engine #(
        .MAX_DATA_BITS(9),
        .BAUD_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .cfg_baud_div (cfg_baud_div),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Requests one frame, then checks tx/busy/frame_done/tx_ready in every cycle of it.
    // Returns #1 after the edge that opens the final stop cycle.
    task automatic run_frame(input string name, input logic [8:0] data, input logic [3:0] nb_cfg,
                             input logic [2:0] par, input logic s2, input logic [31:0] div,
                             input logic [15:0] exp_bits, input int nframe, input bit keep_valid);
        int  w;
        int  de;
        logic last;
        w = 0;
        while (tx_ready !== 1'b1 && w < 64) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({name, "_ready_before"}, tx_ready, 1'b1);
        tx_valid      = 1'b1;
        tx_data       = data;
        cfg_data_bits = nb_cfg;
        cfg_parity    = par;
        cfg_stop2     = s2;
        cfg_baud_div  = div;
        @(posedge clk);
        #1;
        tx_valid = keep_valid;
        // Disturb every input mid-frame; the captured copy must win.
        tx_data       = ~data;
        cfg_data_bits = 4'd6;
        cfg_parity    = 3'd2;
        cfg_stop2     = ~s2;
        cfg_baud_div  = div + 32'd3;
        de = (div == 32'd0) ? 1 : int'(div);
        for (int k = 0; k < nframe; k++) begin
            for (int c = 0; c < de; c++) begin
                last = (k == nframe - 1) && (c == de - 1);
                check($sformatf("%s_tx_b%0d_c%0d", name, k, c), tx, exp_bits[k]);
                check($sformatf("%s_busy_b%0d_c%0d", name, k, c), busy, 1'b1);
                check($sformatf("%s_done_b%0d_c%0d", name, k, c), frame_done, last);
                check($sformatf("%s_ready_b%0d_c%0d", name, k, c), tx_ready, last);
                if (!last) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(posedge clk);
        #1;
        check({name, "_idle_tx"}, tx, 1'b1);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_idle_ready"}, tx_ready, 1'b1);
        check({name, "_idle_done"}, frame_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_valid      = 1'b0;
        tx_data       = '0;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        cfg_baud_div  = 32'd4;

        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", tx_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", tx_ready, 1'b1);
        check("rst_release_tx", tx, 1'b1);

        // 8N1, div 4, 0xA5
        run_frame("f8n1", 9'h0A5, 4'd8, 3'd0, 1'b0, 32'd4, 16'h034A, 10, 1'b0);
        check_idle("f8n1");
        // 7E2 and 7O2, div 2, 0x41
        run_frame("f7e2", 9'h041, 4'd7, 3'd1, 1'b1, 32'd2, 16'h0682, 11, 1'b0);
        check_idle("f7e2");
        run_frame("f7o2", 9'h041, 4'd7, 3'd2, 1'b1, 32'd2, 16'h0782, 11, 1'b0);
        check_idle("f7o2");
        // div 0 and data length clamped up to 5
        run_frame("fdiv0", 9'h01F, 4'd3, 3'd0, 1'b0, 32'd0, 16'h007E, 7, 1'b0);
        check_idle("fdiv0");
        // data length clamped down to 9, mark parity
        run_frame("f9m1", 9'h155, 4'd15, 3'd3, 1'b0, 32'd1, 16'h0EAA, 12, 1'b0);
        check_idle("f9m1");
        // 6 bits, even parity over the low 6 bits only (upper set bits ignored)
        run_frame("f6e1", 9'h1C7, 4'd6, 3'd1, 1'b0, 32'd3, 16'h018E, 9, 1'b0);
        check_idle("f6e1");
        // parity code 5 acts as none
        run_frame("fpar5", 9'h00F, 4'd8, 3'd5, 1'b0, 32'd1, 16'h021E, 10, 1'b0);
        check_idle("fpar5");

        // Back-to-back 8N1 frames with tx_valid held high
        run_frame("b2b_a", 9'h03C, 4'd8, 3'd0, 1'b0, 32'd2, 16'h0278, 10, 1'b1);
        run_frame("b2b_b", 9'h081, 4'd8, 3'd0, 1'b0, 32'd2, 16'h0302, 10, 1'b0);
        check_idle("b2b");

        // No parity on the current frame although cfg_parity goes odd mid-frame; next frame is odd
        run_frame("pchg_a", 9'h00F, 4'd8, 3'd0, 1'b0, 32'd1, 16'h021E, 10, 1'b0);
        check_idle("pchg_a");
        run_frame("pchg_b", 9'h00F, 4'd8, 3'd2, 1'b0, 32'd1, 16'h061E, 11, 1'b0);
        check_idle("pchg_b");

        // Reset in the middle of DATA
        tx_valid      = 1'b1;
        tx_data       = 9'h0A5;
        cfg_data_bits = 4'd8;
        cfg_parity    = 3'd0;
        cfg_stop2     = 1'b0;
        cfg_baud_div  = 32'd4;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre_tx", tx, 1'b0);
        check("mid_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", tx_ready, 1'b0);
        check("mid_rst_done", frame_done, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_rst_hold_done", frame_done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_release_ready", tx_ready, 1'b1);
        check("mid_release_tx", tx, 1'b1);
        check("mid_release_done", frame_done, 1'b0);
        run_frame("post_rst", 9'h0A5, 4'd8, 3'd0, 1'b0, 32'd4, 16'h034A, 10, 1'b0);
        check_idle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL provide parameter MAX_DATA_BITS, default 9, giving the widest supported data field (5..9 legal).
REQ-002 SHALL provide parameter BAUD_WIDTH, default 32, giving the width of the bit-period divisor.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide port tx_valid, input, 1 bit: a frame request is present.
REQ-006 SHALL provide port tx_data, input, MAX_DATA_BITS bits: payload; bit 0 is sent first.
REQ-007 SHALL provide port tx_ready, output, 1 bit: the engine accepts a request this cycle.
REQ-008 SHALL provide port cfg_data_bits, input, 4 bits: data field length.
REQ-009 SHALL provide port cfg_parity, input, 3 bits: 0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none.
REQ-010 SHALL provide port cfg_stop2, input, 1 bit: 0 gives one stop bit, 1 gives two.
REQ-011 SHALL provide port cfg_baud_div, input, BAUD_WIDTH bits: clk cycles per bit.
REQ-012 SHALL provide port tx, output, 1 bit: serial line, idle high.
REQ-013 SHALL provide port busy, output, 1 bit: a frame is in progress.
REQ-014 SHALL provide port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; the path is IDLE->START->DATA->(PARITY if enabled)->STOP->IDLE or START.
REQ-016 SHALL accept a frame on the clk edge where tx_valid && tx_ready; tx_data and all cfg_* inputs are captured on that edge.
REQ-017 SHALL drive tx=0 (START) in the cycle after acceptance; latency from accept to start bit is 1 cycle.
REQ-018 SHALL hold each bit for exactly max(cfg_baud_div,1) cycles using the captured divisor; a divisor of 0 behaves as 1.
REQ-019 SHALL clamp the effective data length to 5 when cfg_data_bits<5 and to MAX_DATA_BITS when cfg_data_bits>MAX_DATA_BITS.
REQ-020 SHALL send data LSB first; bits above the effective length are ignored.
REQ-021 SHALL compute the parity bit over the effective data bits only: even gives XOR of the bits, odd gives its inverse, mark gives 1, space gives 0; with none, the PARITY state is skipped.
REQ-022 SHALL drive tx=1 for one or two bit periods in STOP.
REQ-023 SHALL make the frame length div*(1+N+P+S) cycles, where N is the effective data bits, P is 0 or 1, and S is 1 or 2.
REQ-024 SHALL assert tx_ready in IDLE and in the final cycle of the last stop bit only, so back-to-back frames have no idle gap.
REQ-025 SHALL pulse frame_done high for exactly the final cycle of the last stop bit.
REQ-026 SHALL hold busy high from the cycle after acceptance through the final stop cycle; busy stays high across a back-to-back accept.
REQ-027 SHALL ignore changes to cfg_* and tx_data while a frame is in progress.
REQ-028 SHALL keep tx=1 in IDLE regardless of tx_valid.

Reset
REQ-029 SHALL, while rst_n=0, force tx=1, tx_ready=0, busy=0, frame_done=0, FSM=IDLE, and clear all counters, asynchronously.
REQ-030 SHALL make tx_ready=1 on the first clk edge after rst_n deasserts.
REQ-031 SHALL, on reset mid-frame, abort the frame immediately (tx=1) and produce no frame_done.

Verification
REQ-032 SHALL cover 8N1, div=4, data 0xA5: tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; frame_done in cycle 40.
REQ-033 SHALL cover 7E2, div=2, data 0x41: 7 data bits 1,0,0,0,0,0,1; parity 0; two stop bits; 22 cycles. Repeating with odd parity gives parity 1.
REQ-034 SHALL cover div=0, 5N1, data 0x1F, cfg_data_bits=3: clamped to 5 bits, 1 cycle per bit; tx=0,1,1,1,1,1,1; 7 cycles.
REQ-035 SHALL cover back-to-back: tx_valid held high for two 8N1 frames; the second start bit immediately follows the first stop bit, busy never drops between frames, and frame_done pulses twice.
REQ-036 SHALL cover reset mid-DATA: rst_n=0 gives tx=1 in the same cycle; after release, tx_ready=1 and a new frame transmits correctly.
REQ-037 SHALL cover cfg_parity changed from none to odd mid-frame: the current frame has no parity bit, and the next accepted frame carries odd parity.
